// File: rtl/cmp_red_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cmp_red_seq_pkg                                                            |
// | Opcode constants and FSM state type for the lane compare-reduce sequencer. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cmp_red_seq_pkg;

  // Low bit of the 7-bit ocode selects the operand class; integer ops use INT.
  localparam logic       INT      = 1'b0;
  localparam logic [6:0] VREDMINU = {6'b000100, INT};
  localparam logic [6:0] VREDMIN  = {6'b000101, INT};
  localparam logic [6:0] VREDMAXU = {6'b000110, INT};
  localparam logic [6:0] VREDMAX  = {6'b000111, INT};
  localparam logic [6:0] VMSEQ    = {6'b011000, INT};

  typedef enum logic [1:0] {
    RED_IDLE  = 2'd0,
    RED_RUN   = 2'd1,
    RED_DRAIN = 2'd2,
    RED_FIN   = 2'd3
  } red_state_e;

  function automatic logic is_red_op(input logic [6:0] ocode);
    return (ocode == VREDMIN) || (ocode == VREDMINU) ||
           (ocode == VREDMAX) || (ocode == VREDMAXU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_red_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cmp_red_seq_if                                                             |
// | Issue handshake, VRF read port and CMP operand bundle of the sequencer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface cmp_red_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_VL     = 32
);
  localparam int IDX_W = (MAX_VL > 1) ? $clog2(MAX_VL) : 1;
  localparam int VL_W  = $clog2(MAX_VL + 1);

  logic                  start_i;
  logic                  ready_o;
  logic                  busy_o;
  logic [6:0]            ocode_i;
  logic [VL_W-1:0]       vl_i;
  logic                  vm_i;
  logic [DATA_WIDTH-1:0] scalar_i;
  logic                  rd_en_o;
  logic [IDX_W-1:0]      rd_idx_o;
  logic [DATA_WIDTH-1:0] elem_i;
  logic                  mask_i;
  logic                  cmp_en_o;
  logic [DATA_WIDTH-1:0] cmp_a_o;
  logic [DATA_WIDTH-1:0] cmp_b_o;
  logic [6:0]            cmp_ocode_o;
  logic [DATA_WIDTH-1:0] cmp_result_i;
  logic                  done_o;
  logic                  err_o;
  logic [DATA_WIDTH-1:0] result_o;

  modport slave (
    input  start_i, ocode_i, vl_i, vm_i, scalar_i, elem_i, mask_i, cmp_result_i,
    output ready_o, busy_o, rd_en_o, rd_idx_o, cmp_en_o, cmp_a_o, cmp_b_o,
           cmp_ocode_o, done_o, err_o, result_o
  );

  modport master (
    output start_i, ocode_i, vl_i, vm_i, scalar_i, elem_i, mask_i, cmp_result_i,
    input  ready_o, busy_o, rd_en_o, rd_idx_o, cmp_en_o, cmp_a_o, cmp_b_o,
           cmp_ocode_o, done_o, err_o, result_o
  );
endinterface
`default_nettype wire

// File: rtl/cmp_red_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cmp_red_seq                                                                |
// | Walks one lane's vector slice through the shared CMP for min/max reduces.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cmp_red_seq
  import cmp_red_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_VL     = 32
) (
  input  wire logic    module_clk_i,
  input  wire logic    rst_ni,
  cmp_red_seq_if.slave bus
);

  localparam int              IDX_W    = (MAX_VL > 1) ? $clog2(MAX_VL) : 1;
  localparam int              VL_W     = $clog2(MAX_VL + 1);
  localparam logic [VL_W-1:0] c_MAX_VL = VL_W'(MAX_VL);

  red_state_e            r_state;
  red_state_e            w_state_nxt;
  logic [IDX_W-1:0]      r_cnt;
  logic [VL_W-1:0]       r_vl;
  logic                  r_vm;
  logic                  r_err;
  logic                  r_rd_vld;
  logic [6:0]            r_ocode;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_result;

  logic                  w_accept;
  logic                  w_legal;
  logic                  w_last;
  logic                  w_active;
  logic [VL_W-1:0]       w_vl_clamp;
  logic [DATA_WIDTH-1:0] w_acc_nxt;

  assign w_accept   = bus.start_i & (r_state == RED_IDLE);
  assign w_legal    = is_red_op(bus.ocode_i);
  assign w_vl_clamp = (bus.vl_i > c_MAX_VL) ? c_MAX_VL : bus.vl_i;
  assign w_last     = (VL_W'(r_cnt) + VL_W'(1)) == r_vl;
  // Read data lands one cycle after the strobe; masked-off elements leave acc untouched.
  assign w_active   = r_rd_vld & (r_vm | bus.mask_i);
  assign w_acc_nxt  = w_active ? bus.cmp_result_i : r_acc;

  always_ff @(posedge module_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RED_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RED_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_legal && (w_vl_clamp != '0)) ? RED_RUN : RED_FIN;
        end
      end
      RED_RUN: begin
        if (w_last) begin
          w_state_nxt = RED_DRAIN;
        end
      end
      RED_DRAIN: w_state_nxt = RED_FIN;
      RED_FIN:   w_state_nxt = RED_IDLE;
      default:   w_state_nxt = RED_IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o     = (r_state == RED_IDLE);
    bus.busy_o      = (r_state == RED_RUN) || (r_state == RED_DRAIN);
    bus.rd_en_o     = (r_state == RED_RUN);
    bus.rd_idx_o    = r_cnt;
    bus.done_o      = (r_state == RED_FIN);
    bus.err_o       = (r_state == RED_FIN) & r_err;
    bus.cmp_en_o    = w_active;
    bus.cmp_a_o     = r_acc;
    bus.cmp_b_o     = bus.elem_i;
    bus.cmp_ocode_o = r_ocode;
    bus.result_o    = r_result;
  end

  always_ff @(posedge module_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_vl     <= '0;
      r_vm     <= 1'b0;
      r_err    <= 1'b0;
      r_rd_vld <= 1'b0;
      r_ocode  <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      r_rd_vld <= (r_state == RED_RUN);
      if (w_accept) begin
        r_cnt   <= '0;
        r_vl    <= w_vl_clamp;
        r_vm    <= bus.vm_i;
        r_err   <= ~w_legal;
        r_ocode <= bus.ocode_i;
        r_acc   <= bus.scalar_i;
      end else begin
        r_acc <= w_acc_nxt;
        if ((r_state == RED_RUN) && !w_last) begin
          r_cnt <= r_cnt + IDX_W'(1);
        end
      end
      // Capture on entry to FIN so result_o is already valid while done_o is high.
      if (w_state_nxt == RED_FIN) begin
        r_result <= w_accept ? bus.scalar_i : w_acc_nxt;
      end
    end
  end

endmodule
`default_nettype wire
